// File: rtl/native_in_port.sv
// Write-side native video port: captures a vsync/hsync/de stream into VDMA FIFO
// writes, enforcing the latched frame geometry and emitting alignment pulses.
module native_in_port #(
    parameter int    DSIZE = 24,
    parameter string MODE  = "ONCE"
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             in_vsync,
    input  logic             in_hsync,
    input  logic             in_de,
    input  logic [DSIZE-1:0] in_data,
    output logic             wr_en,
    output logic [DSIZE-1:0] wdata,
    output logic             falign,
    output logic             lalign,
    output logic             ealign,
    output logic             line_short,
    output logic             line_long,
    output logic             frame_short,
    output logic             busy
);

    localparam bit LINE_MODE = (MODE == "LINE");

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        vs_q, de_q;
    logic [15:0] pcnt, lcnt;
    logic [15:0] hact_s, vact_s;

    logic        vs_fall, de_fall, geo_ok;
    logic [15:0] lcnt_inc;

    logic [15:0]      pcnt_nx, lcnt_nx;
    logic             wr_nx, fal_nx, lal_nx, eal_nx;
    logic             ls_nx, ll_nx, fs_nx;
    logic [DSIZE-1:0] wdata_nx;

    // hsync is carried for interface symmetry only
    logic unused_hsync;
    assign unused_hsync = in_hsync;

    assign vs_fall  = vs_q & ~in_vsync;
    assign de_fall  = de_q & ~in_de;
    assign geo_ok   = (vactive != 16'd0) && (hactive != 16'd0);
    assign lcnt_inc = lcnt + 16'd1;
    assign busy     = (state == CAPTURE);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        lcnt_nx  = lcnt;
        wdata_nx = wdata;
        wr_nx    = 1'b0;
        fal_nx   = 1'b0;
        lal_nx   = 1'b0;
        eal_nx   = 1'b0;
        ls_nx    = 1'b0;
        ll_nx    = 1'b0;
        fs_nx    = 1'b0;
        if (vs_fall) begin
            // vs_fall beats a coincident de_fall; the closing line is dropped
            fal_nx   = geo_ok || (state == CAPTURE);
            fs_nx    = (state == CAPTURE);
            pcnt_nx  = 16'd0;
            lcnt_nx  = 16'd0;
            state_nx = geo_ok ? CAPTURE : WAIT;
            if (geo_ok && in_de) begin
                wr_nx    = 1'b1;
                wdata_nx = in_data;
                pcnt_nx  = 16'd1;
            end
        end else if (state == CAPTURE) begin
            if (de_fall) begin
                ls_nx   = (pcnt < hact_s);
                lal_nx  = LINE_MODE;
                pcnt_nx = 16'd0;
                lcnt_nx = lcnt_inc;
                if (lcnt_inc == vact_s) begin
                    eal_nx   = 1'b1;
                    state_nx = HOLD;
                end
            end else if (in_de) begin
                if (pcnt < hact_s) begin
                    wr_nx    = 1'b1;
                    wdata_nx = in_data;
                    pcnt_nx  = pcnt + 16'd1;
                end else begin
                    ll_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            pcnt        <= 16'd0;
            lcnt        <= 16'd0;
            hact_s      <= 16'd0;
            vact_s      <= 16'd0;
            wr_en       <= 1'b0;
            wdata       <= '0;
            falign      <= 1'b0;
            lalign      <= 1'b0;
            ealign      <= 1'b0;
            line_short  <= 1'b0;
            line_long   <= 1'b0;
            frame_short <= 1'b0;
        end else begin
            vs_q        <= in_vsync;
            de_q        <= in_de;
            pcnt        <= pcnt_nx;
            lcnt        <= lcnt_nx;
            if (vs_fall) begin
                hact_s <= hactive;
                vact_s <= vactive;
            end
            wr_en       <= wr_nx;
            wdata       <= wdata_nx;
            falign      <= fal_nx;
            lalign      <= lal_nx;
            ealign      <= eal_nx;
            line_short  <= ls_nx;
            line_long   <= ll_nx;
            frame_short <= fs_nx;
        end
    end

endmodule

// File: tb/tb_native_in_port.sv
// Bench for native_in_port: LINE and ONCE instances driven together and
// compared every cycle against a frame-rule reference model.
module tb_native_in_port;

    localparam int DW = 24;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   vactive = 16'd0;
    logic [15:0]   hactive = 16'd0;
    logic          in_vsync = 1'b0;
    logic          in_hsync = 1'b0;
    logic          in_de = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          l_wr, l_fal, l_lal, l_eal, l_ls, l_ll, l_fs, l_busy;
    logic          o_wr, o_fal, o_lal, o_eal, o_ls, o_ll, o_fs, o_busy;
    logic [DW-1:0] l_wdata, o_wdata;

    native_in_port #(.DSIZE(DW), .MODE("LINE")) u_line (
        .clock(clock), .rst_n(rst_n), .vactive(vactive),
        .hactive(hactive), .in_vsync(in_vsync), .in_hsync(in_hsync),
        .in_de(in_de), .in_data(in_data), .wr_en(l_wr),
        .wdata(l_wdata), .falign(l_fal), .lalign(l_lal),
        .ealign(l_eal), .line_short(l_ls), .line_long(l_ll),
        .frame_short(l_fs), .busy(l_busy)
    );

    native_in_port #(.DSIZE(DW), .MODE("ONCE")) u_once (
        .clock(clock), .rst_n(rst_n), .vactive(vactive),
        .hactive(hactive), .in_vsync(in_vsync), .in_hsync(in_hsync),
        .in_de(in_de), .in_data(in_data), .wr_en(o_wr),
        .wdata(o_wdata), .falign(o_fal), .lalign(o_lal),
        .ealign(o_eal), .line_short(o_ls), .line_long(o_ll),
        .frame_short(o_fs), .busy(o_busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // model state: 0 idle, 1 capturing, 2 frame done
    int            ms = 0;
    int            px = 0;
    int            ln = 0;
    int            h_lat = 0;
    int            v_lat = 0;
    logic          pvs = 1'b0;
    logic          pde = 1'b0;
    logic [7:0]    exp_l, exp_o;
    logic [DW-1:0] exp_d;

    int            n_wr, n_lal_l, n_lal_o, n_long, n_short, n_eal, n_fal;
    logic [DW-1:0] last_d;
    logic [DW-1:0] dcnt = 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model();
        logic vf, df, ok;
        logic wr, fal, lal, eal, ls, ll, fs;
        {wr, fal, lal, eal, ls, ll, fs} = '0;
        if (!rst_n) begin
            ms = 0; px = 0; ln = 0;
            pvs = 1'b0; pde = 1'b0;
        end else begin
            vf = pvs && !in_vsync;
            df = pde && !in_de;
            if (vf) begin
                ok = (vactive != 0) && (hactive != 0);
                fal = ok || (ms == 1);
                fs = (ms == 1);
                h_lat = int'(hactive);
                v_lat = int'(vactive);
                px = 0; ln = 0;
                ms = ok ? 1 : 0;
                if (ok && in_de) begin
                    wr = 1'b1; exp_d = in_data; px = 1;
                end
            end else if (ms == 1 && df) begin
                ls = (px < h_lat);
                lal = 1'b1;
                px = 0;
                ln++;
                if (ln == v_lat) begin
                    eal = 1'b1; ms = 2;
                end
            end else if (ms == 1 && in_de) begin
                if (px < h_lat) begin
                    wr = 1'b1; exp_d = in_data; px++;
                end else begin
                    ll = 1'b1;
                end
            end
            pvs = in_vsync;
            pde = in_de;
        end
        exp_l = {wr, fal, lal, eal, ls, ll, fs, ms == 1};
        exp_o = {wr, fal, 1'b0, eal, ls, ll, fs, ms == 1};
    endtask

    task automatic cyc(input logic vs, input logic de);
        in_vsync = vs;
        in_de    = de;
        in_hsync = 1'($urandom);
        in_data  = de ? dcnt : DW'($urandom);
        if (de) dcnt = dcnt + 1;
        @(posedge clock);
        model();
        #1;
        check("line_out", {l_wr, l_fal, l_lal, l_eal, l_ls, l_ll,
                           l_fs, l_busy}, exp_l);
        check("once_out", {o_wr, o_fal, o_lal, o_eal, o_ls, o_ll,
                           o_fs, o_busy}, exp_o);
        if (exp_l[7]) begin
            check("l_wdata", l_wdata, exp_d);
            check("o_wdata", o_wdata, exp_d);
        end
        n_wr    += int'(l_wr);
        n_lal_l += int'(l_lal);
        n_lal_o += int'(o_lal);
        n_long  += int'(l_ll);
        n_short += int'(l_ls);
        n_eal   += int'(l_eal);
        n_fal   += int'(l_fal);
        if (l_wr) last_d = l_wdata;
    endtask

    task automatic clr();
        n_wr = 0; n_lal_l = 0; n_lal_o = 0; n_long = 0;
        n_short = 0; n_eal = 0; n_fal = 0;
    endtask

    task automatic vs_start();
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1);
        cyc(0, 0);
        cyc(0, 0);
    endtask

    initial begin
        clr();
        repeat (3) cyc(0, 0);
        check("rst_busy", l_busy, 0);
        check("rst_wr", l_wr, 0);
        check("rst_wdata", l_wdata, 0);
        rst_n = 1'b1;
        cyc(0, 0);

        // nominal 4x8, incrementing data
        vactive = 16'd4; hactive = 16'd8; dcnt = 1;
        clr();
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);
        check("nom_falign", l_fal, 1);
        check("nom_busy", l_busy, 1);
        cyc(0, 0);
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 8; i++) cyc(0, 1);
            cyc(0, 0);
        end
        check("nom_ealign", l_eal, 1);
        check("nom_busy_drop", l_busy, 0);
        cyc(0, 0);
        check("nom_wr", n_wr, 32);
        check("nom_last", last_d, 32'h20);
        check("nom_lal_line", n_lal_l, 4);
        check("nom_lal_once", n_lal_o, 0);

        // long line then normal line
        vactive = 16'd2; hactive = 16'd8;
        vs_start(); clr();
        line(11);
        check("long_wr", n_wr, 8);
        check("long_cnt", n_long, 3);
        line(8);
        check("long_wr2", n_wr, 16);
        check("long_eal", n_eal, 1);

        // short line
        vs_start(); clr();
        line(5);
        line(8);
        check("short_wr", n_wr, 13);
        check("short_cnt", n_short, 1);
        check("short_eal", n_eal, 1);

        // short frame, then full frame
        vactive = 16'd4;
        vs_start(); clr();
        line(8); line(8);
        cyc(1, 0); cyc(1, 0);
        cyc(0, 0);
        check("sf_fs", l_fs, 1);
        check("sf_fal", l_fal, 1);
        cyc(0, 0);
        clr();
        for (int l = 0; l < 4; l++) line(8);
        check("sf_eal", n_eal, 1);

        // de_fall coincident with vs_fall
        vs_start();
        line(8);
        for (int i = 0; i < 7; i++) cyc(0, 1);
        cyc(1, 1);
        clr();
        cyc(0, 0);
        check("co_fs", l_fs, 1);
        check("co_fal", l_fal, 1);
        check("co_lal", l_lal, 0);
        check("co_eal", l_eal, 0);
        check("co_ls", l_ls, 0);

        // pixel on the vs_fall cycle opens the new frame
        line(3);
        cyc(1, 0);
        clr();
        cyc(0, 1);
        check("vp_wr", l_wr, 1);
        check("vp_fs", l_fs, 1);
        for (int i = 0; i < 7; i++) cyc(0, 1);
        cyc(0, 0);
        check("vp_wr_n", n_wr, 8);
        check("vp_ls", n_short, 0);
        check("vp_ll", n_long, 0);

        // geometry change mid-frame
        vactive = 16'd2; hactive = 16'd8;
        vs_start(); clr();
        hactive = 16'd4;
        line(8); line(8);
        check("geo_cur_wr", n_wr, 16);
        vs_start(); clr();
        line(8); line(8);
        check("geo_new_wr", n_wr, 8);
        check("geo_new_ll", n_long, 8);

        // zero vactive
        vactive = 16'd0;
        clr();
        vs_start();
        line(8); line(8);
        check("zero_wr", n_wr, 0);
        check("zero_fal", n_fal, 0);

        // reset mid-line
        vactive = 16'd2; hactive = 16'd8;
        vs_start();
        for (int i = 0; i < 3; i++) cyc(0, 1);
        rst_n = 1'b0;
        cyc(0, 1);
        check("mr_out", {l_wr, l_fal, l_eal, l_busy, l_ll}, 0);
        rst_n = 1'b1;
        clr();
        line(5); line(8);
        check("mr_nowr", n_wr, 0);
        vs_start();
        line(8); line(8);
        check("mr_wr", n_wr, 16);
        check("mr_eal", n_eal, 1);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int h, nl;
            vactive = 16'($urandom_range(0, 4));
            h = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 10);
            hactive = 16'(h);
            nl = $urandom_range(1, 5);
            vs_start();
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 7) == 0)
                    hactive = 16'($urandom_range(0, 10));
                for (int i = $urandom_range(1, h + 3); i > 0; i--)
                    cyc(0, 1);
                repeat ($urandom_range(1, 3)) cyc(0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
